paddle_engine: RTL

PADDLE_ENGINE -- requirements
Module: paddle_engine

---
 rtl/paddle_engine.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/paddle_engine.sv
`default_nettype none
// ============================================================================
// paddle_engine : accelerating paddle, ball collision/zone detect, catch/launch
// Rev 1.0
// ============================================================================
module paddle_engine #(
   parameter int X_W          = 9,
   parameter int Y_W          = 8,
   parameter int PADDLE_W     = 32,
   parameter int PADDLE_Y     = 220,
   parameter int HIT_DEPTH    = 4,
   parameter int X_MIN        = 8,
   parameter int X_MAX        = 280,
   parameter int RESET_X      = 152,
   parameter int MAX_SPEED    = 4,
   parameter int ACCEL_FRAMES = 4,
   parameter int ZONES        = 4
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       frame_tick,
   input  logic [1:0]                 go,
   input  logic                       catch_en,
   input  logic                       launch,
   input  logic [X_W-1:0]             ball_x,
   input  logic [Y_W-1:0]             ball_y,
   output logic [X_W-1:0]             paddle_x,
   output logic [3:0]                 speed,
   output logic                       draw,
   output logic                       hit_valid,
   output logic [$clog2(ZONES)-1:0]   hit_zone,
   output logic                       ball_held,
   output logic [X_W-1:0]             hold_x
);

   localparam int XE    = X_W + 1;
   localparam int CNT_W = $clog2(ACCEL_FRAMES + 1);
   localparam int ZW    = $clog2(ZONES);
   localparam int SH    = $clog2(PADDLE_W / ZONES);

   localparam logic [0:0] FREE = 1'b0;
   localparam logic [0:0] HELD = 1'b1;

   logic [0:0]       state;
   logic [CNT_W-1:0] frame_cnt, cnt_nxt;
   logic [1:0]       last_dir;
   logic [3:0]       speed_nxt;
   logic             moving;
   logic [XE-1:0]    x_ext, spd_ext, x_nxt_ext, bx_ext, diff, zone_raw;
   logic [X_W-1:0]   x_nxt, offset;
   logic             y_in, in_box, prev_in_box, hit_det;
   logic [ZW-1:0]    zone;

   // Speed/counter update for a tick; the new speed drives this tick's move
   always_comb begin
      moving    = go[1] ^ go[0];
      speed_nxt = speed;
      cnt_nxt   = frame_cnt;
      if (!moving) begin
         speed_nxt = 4'd0;
         cnt_nxt   = '0;
      end else if (go == last_dir) begin
         if (frame_cnt == CNT_W'(ACCEL_FRAMES - 1)) begin
            cnt_nxt = '0;
            if (speed < 4'(MAX_SPEED))
               speed_nxt = speed + 4'd1;
         end else begin
            cnt_nxt = frame_cnt + CNT_W'(1);
         end
      end else begin
         speed_nxt = 4'd1;
         cnt_nxt   = '0;
      end
   end

   always_comb begin
      x_ext     = {1'b0, paddle_x};
      spd_ext   = XE'(speed_nxt);
      x_nxt_ext = x_ext;
      if (go == 2'b01) begin
         x_nxt_ext = x_ext + spd_ext;
         if (x_nxt_ext > XE'(X_MAX))
            x_nxt_ext = XE'(X_MAX);
      end else if (go == 2'b10) begin
         // compare before subtracting so the left edge cannot wrap
         if (x_ext < XE'(X_MIN) + spd_ext)
            x_nxt_ext = XE'(X_MIN);
         else
            x_nxt_ext = x_ext - spd_ext;
      end
      x_nxt = x_nxt_ext[X_W-1:0];
   end

   // Collision box uses the registered (pre-tick) paddle position
   always_comb begin
      bx_ext   = {1'b0, ball_x};
      y_in     = (ball_y >= Y_W'(PADDLE_Y)) && (ball_y <= Y_W'(PADDLE_Y + HIT_DEPTH - 1));
      in_box   = y_in && (bx_ext >= x_ext) && (bx_ext <= x_ext + XE'(PADDLE_W));
      hit_det  = in_box && !prev_in_box && (state == FREE);
      diff     = bx_ext - x_ext;
      zone_raw = diff >> SH;
      if (zone_raw > XE'(ZONES - 1))
         zone = ZW'(ZONES - 1);
      else
         zone = zone_raw[ZW-1:0];
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         paddle_x    <= X_W'(RESET_X);
         speed       <= 4'd0;
         frame_cnt   <= '0;
         last_dir    <= 2'b00;
         draw        <= 1'b1;
         hit_valid   <= 1'b0;
         hit_zone    <= '0;
         prev_in_box <= 1'b0;
         state       <= FREE;
         offset      <= '0;
      end else begin
         draw <= 1'b0;
         if (frame_tick) begin
            paddle_x  <= x_nxt;
            speed     <= speed_nxt;
            frame_cnt <= cnt_nxt;
            last_dir  <= moving ? go : 2'b00;
            draw      <= (x_nxt != paddle_x);
         end
         prev_in_box <= in_box;
         hit_valid   <= hit_det;
         if (hit_det)
            hit_zone <= zone;
         case (state)
            FREE: if (hit_det && catch_en) begin
               state  <= HELD;
               offset <= diff[X_W-1:0];
            end
            HELD: if (launch)
               state <= FREE;
            default: state <= FREE;
         endcase
      end
   end

   assign ball_held = (state == HELD);
   assign hold_x    = paddle_x + offset;

endmodule
`default_nettype wire
